// File: rtl/cv32e40p_fetch_realigner_pkg.sv
// Shared types and helpers for the fetch realigner: state encoding,
// halfword step and the compressed-instruction test.
package cv32e40p_realign_pkg;

   typedef enum logic [1:0] {
      ALIGNED = 2'd0,
      RES     = 2'd1,
      BR_HALF = 2'd2
   } realign_state_e;

   localparam int unsigned HALF_INC = 2;

   // An RVC instruction is anything whose two low bits are not 2'b11.
   function automatic logic is_rvc(input logic [1:0] x);
      return x != 2'b11;
   endfunction

endpackage

// File: rtl/cv32e40p_fetch_realigner_if.sv
// Prefetch-side and decode-side handshake bundle of the fetch realigner,
// plus the branch flush request.
interface cv32e40p_fetch_realigner_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  fetch_valid_i;
   logic                  fetch_ready_o;
   logic [31:0]           fetch_rdata_i;
   logic [ADDR_WIDTH-1:0] fetch_addr_i;
   logic                  instr_valid_o;
   logic                  instr_ready_i;
   logic [31:0]           instr_o;
   logic [ADDR_WIDTH-1:0] instr_addr_o;
   logic                  branch_i;
   logic [ADDR_WIDTH-1:0] branch_addr_i;

   // Realigner view.
   modport slave (
      input  fetch_valid_i, fetch_rdata_i, fetch_addr_i, instr_ready_i,
             branch_i, branch_addr_i,
      output fetch_ready_o, instr_valid_o, instr_o, instr_addr_o
   );

   // Prefetcher/decoder/controller view.
   modport master (
      output fetch_valid_i, fetch_rdata_i, fetch_addr_i, instr_ready_i,
             branch_i, branch_addr_i,
      input  fetch_ready_o, instr_valid_o, instr_o, instr_addr_o
   );
endinterface

// File: rtl/cv32e40p_fetch_realigner.sv
// Converts word-aligned fetch words into one RVC or 32-bit instruction per
// handshake, keeping the upper halfword of a split word as residue.
module cv32e40p_fetch_realigner
   import cv32e40p_realign_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input logic                      clk,
   input logic                      rst_n,
   cv32e40p_fetch_realigner_if.slave bus
);

   realign_state_e        st_q, st_d;
   logic [15:0]           res_q, res_d;
   logic [ADDR_WIDTH-1:0] res_addr_q, res_addr_d;

   logic                  instr_valid;
   logic                  fetch_ready;
   logic [31:0]           instr;
   logic [ADDR_WIDTH-1:0] instr_addr;
   logic [ADDR_WIDTH-1:0] next_half_addr;
   logic                  unused_branch_bits;

   // Only the halfword select of the branch target matters here.
   assign unused_branch_bits = ^{bus.branch_addr_i[ADDR_WIDTH-1:2], bus.branch_addr_i[0]};

   assign next_half_addr = bus.fetch_addr_i + ADDR_WIDTH'(HALF_INC);

   always_comb begin
      st_d        = st_q;
      res_d       = res_q;
      res_addr_d  = res_addr_q;
      instr_valid = 1'b0;
      fetch_ready = 1'b0;
      instr       = '0;
      instr_addr  = '0;

      if (!rst_n) begin
         // Outputs stay quiet while reset is held; state is cleared in the register.
      end else if (bus.branch_i) begin
         st_d  = bus.branch_addr_i[1] ? BR_HALF : ALIGNED;
         res_d = '0;
      end else begin
         unique case (st_q)
            ALIGNED: begin
               if (bus.fetch_valid_i) begin
                  instr_valid = 1'b1;
                  fetch_ready = bus.instr_ready_i;
                  instr_addr  = bus.fetch_addr_i;
                  if (is_rvc(bus.fetch_rdata_i[1:0])) begin
                     instr = {16'h0, bus.fetch_rdata_i[15:0]};
                     if (bus.instr_ready_i) begin
                        res_d      = bus.fetch_rdata_i[31:16];
                        res_addr_d = next_half_addr;
                        st_d       = RES;
                     end
                  end else begin
                     instr = bus.fetch_rdata_i;
                  end
               end
            end

            RES: begin
               instr_addr = res_addr_q;
               if (is_rvc(res_q[1:0])) begin
                  // Residue is a whole instruction: emit it without touching the fetch side.
                  instr       = {16'h0, res_q};
                  instr_valid = 1'b1;
                  if (bus.instr_ready_i) begin
                     st_d = ALIGNED;
                  end
               end else begin
                  instr       = {bus.fetch_rdata_i[15:0], res_q};
                  instr_valid = bus.fetch_valid_i;
                  fetch_ready = bus.instr_ready_i;
                  if (bus.fetch_valid_i && bus.instr_ready_i) begin
                     res_d      = bus.fetch_rdata_i[31:16];
                     res_addr_d = next_half_addr;
                  end
               end
            end

            BR_HALF: begin
               // Target is the upper halfword: discard the lower one.
               fetch_ready = 1'b1;
               if (bus.fetch_valid_i) begin
                  res_d      = bus.fetch_rdata_i[31:16];
                  res_addr_d = next_half_addr;
                  st_d       = RES;
               end
            end

            default: begin
               st_d = ALIGNED;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q       <= ALIGNED;
         res_q      <= '0;
         res_addr_q <= '0;
      end else begin
         st_q       <= st_d;
         res_q      <= res_d;
         res_addr_q <= res_addr_d;
      end
   end

   assign bus.instr_valid_o = instr_valid;
   assign bus.fetch_ready_o = fetch_ready;
   assign bus.instr_o       = instr;
   assign bus.instr_addr_o  = instr_addr;

endmodule

// File: tb/tb_cv32e40p_fetch_realigner.sv
// Self-checking bench: directed scenarios plus random fetch streams compared
// against a halfword-parsing reference model.
module tb_cv32e40p_fetch_realigner;

   localparam int AW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cv32e40p_fetch_realigner_if #(.ADDR_WIDTH(AW)) bus ();

   cv32e40p_fetch_realigner #(.ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [31:0] mem [64];
   logic [31:0] exp_instr [$];
   logic [31:0] exp_addr  [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total = n_total + 1;
      assert (obs === expv) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: split the words into halfwords starting at the target and parse
   // instruction by instruction; an incomplete trailing 32-bit instruction is not emitted.
   task automatic build_model(input logic [31:0] base, input bit off, input int n);
      logic [15:0] h [128];
      int k;
      exp_instr.delete();
      exp_addr.delete();
      for (int i = 0; i < n; i++) begin
         h[2*i]   = mem[i][15:0];
         h[2*i+1] = mem[i][31:16];
      end
      k = off ? 1 : 0;
      while (k < 2*n) begin
         if (h[k][1:0] != 2'b11) begin
            exp_instr.push_back({16'h0, h[k]});
            exp_addr.push_back(base + 32'(2*k));
            k = k + 1;
         end else if (k + 1 < 2*n) begin
            exp_instr.push_back({h[k+1], h[k]});
            exp_addr.push_back(base + 32'(2*k));
            k = k + 2;
         end else begin
            k = 2*n;
         end
      end
   endtask

   task automatic branch_to(input logic [31:0] target);
      @(negedge clk);
      bus.branch_i      = 1'b1;
      bus.branch_addr_i = target;
      bus.fetch_valid_i = 1'($urandom_range(0, 1));
      bus.fetch_rdata_i = $urandom;
      bus.instr_ready_i = 1'b1;
      #1;
      chk("branch_instr_valid", {31'b0, bus.instr_valid_o}, 32'd0);
      chk("branch_fetch_ready", {31'b0, bus.fetch_ready_o}, 32'd0);
      @(posedge clk);
   endtask

   task automatic stream(input logic [31:0] base, input bit off, input int n,
                         input bit rnd, output int consumed);
      int   wi;
      int   cyc;
      bit   hold;
      bit   fv;
      bit   took;
      logic [31:0] ei, ea;
      wi = 0; cyc = 0; hold = 0; fv = 0;
      branch_to(base + (off ? 32'd2 : 32'd0));
      build_model(base, off, n);
      while (!(exp_instr.size() == 0 && wi == n)) begin
         if (cyc >= 2000) begin
            chk("stream_timeout_left", 32'(exp_instr.size() + (n - wi)), 32'd0);
            break;
         end
         @(negedge clk);
         bus.branch_i = 1'b0;
         if (!hold) fv = (wi < n) && (!rnd || $urandom_range(0, 3) != 0);
         bus.fetch_valid_i = fv;
         bus.fetch_rdata_i = (wi < n) ? mem[wi] : $urandom;
         bus.fetch_addr_i  = base + 32'(4*wi);
         bus.instr_ready_i = !rnd || $urandom_range(0, 2) != 0;
         #1;
         if (bus.instr_valid_o && !bus.instr_ready_i)
            chk("no_fetch_during_stall", {31'b0, bus.fetch_ready_o}, 32'd0);
         if (bus.instr_valid_o && bus.instr_ready_i) begin
            if (exp_instr.size() == 0) begin
               chk("unexpected_instr", {31'b0, bus.instr_valid_o}, 32'd0);
            end else begin
               ei = exp_instr.pop_front();
               ea = exp_addr.pop_front();
               chk("instr", bus.instr_o, ei);
               chk("instr_addr", bus.instr_addr_o, ea);
               // Only an RVC residue at an odd halfword is emitted without consuming a word.
               chk("fetch_ready_on_hs", {31'b0, bus.fetch_ready_o},
                   {31'b0, ~(ea[1] & (ei[1:0] != 2'b11))});
               $display("instr %08h @ %08h", bus.instr_o, bus.instr_addr_o);
            end
         end
         took = fv && bus.fetch_ready_o;
         hold = fv && !bus.fetch_ready_o;
         @(posedge clk);
         if (took) wi = wi + 1;
         cyc = cyc + 1;
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus.branch_i      = 1'b0;
         bus.fetch_valid_i = 1'b0;
         bus.instr_ready_i = 1'b1;
         #1;
         chk("idle_no_instr", {31'b0, bus.instr_valid_o}, 32'd0);
         @(posedge clk);
      end
      consumed = wi;
   endtask

   function automatic logic [15:0] rand_half();
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
      else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
      return h;
   endfunction

   initial begin
      int c;
      int n;
      logic [31:0] base;
      bit off;

      // Reset held with a word on offer.
      bus.branch_i      = 1'b0;
      bus.branch_addr_i = '0;
      bus.fetch_valid_i = 1'b1;
      bus.fetch_rdata_i = 32'h0000_0013;
      bus.fetch_addr_i  = 32'h40;
      bus.instr_ready_i = 1'b1;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("rst_instr_valid", {31'b0, bus.instr_valid_o}, 32'd0);
         chk("rst_fetch_ready", {31'b0, bus.fetch_ready_o}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.fetch_valid_i = 1'b0;
      #1;
      chk("post_rst_valid", {31'b0, bus.instr_valid_o}, 32'd0);
      chk("post_rst_ready", {31'b0, bus.fetch_ready_o}, 32'd0);
      chk("post_rst_instr", bus.instr_o, 32'd0);
      chk("post_rst_addr", bus.instr_addr_o, 32'd0);
      @(negedge clk);
      bus.fetch_valid_i = 1'b1;
      #1;
      chk("aligned_after_rst_valid", {31'b0, bus.instr_valid_o}, 32'd1);
      chk("aligned_after_rst_instr", bus.instr_o, 32'h0000_0013);
      chk("aligned_after_rst_addr", bus.instr_addr_o, 32'h40);
      @(posedge clk);

      // Two RVC in one word.
      mem[0] = 32'h4501_4581;
      stream(32'h100, 1'b0, 1, 1'b0, c);
      chk("two_rvc_words_used", 32'(c), 32'd1);

      // 32-bit instruction straddling two words.
      mem[0] = 32'h0093_4581;
      mem[1] = 32'h1234_0513;
      stream(32'h200, 1'b0, 2, 1'b0, c);
      chk("straddle_words_used", 32'(c), 32'd2);

      // Branch to the upper halfword.
      mem[0] = 32'hAAAA_0001;
      stream(32'h300, 1'b1, 1, 1'b0, c);

      // Stall on a 32-bit instruction.
      branch_to(32'h400);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.branch_i      = 1'b0;
         bus.fetch_valid_i = 1'b1;
         bus.fetch_rdata_i = 32'h0000_0013;
         bus.fetch_addr_i  = 32'h400;
         bus.instr_ready_i = 1'b0;
         #1;
         chk("stall_valid", {31'b0, bus.instr_valid_o}, 32'd1);
         chk("stall_instr", bus.instr_o, 32'h0000_0013);
         chk("stall_addr", bus.instr_addr_o, 32'h400);
         chk("stall_fetch_ready", {31'b0, bus.fetch_ready_o}, 32'd0);
      end
      @(negedge clk);
      bus.instr_ready_i = 1'b1;
      #1;
      chk("stall_release_ready", {31'b0, bus.fetch_ready_o}, 32'd1);
      $display("instr %08h @ %08h", bus.instr_o, bus.instr_addr_o);
      @(negedge clk);
      bus.fetch_valid_i = 1'b0;
      #1;
      chk("stall_done_idle", {31'b0, bus.instr_valid_o}, 32'd0);

      // Branch while a 32-bit residue waits for its second half.
      mem[0] = 32'h0013_4581;
      stream(32'h500, 1'b0, 1, 1'b0, c);
      mem[0] = 32'h4505_4501;
      stream(32'h600, 1'b0, 1, 1'b0, c);

      // Reset mid-stream beats a concurrent branch and drops the residue.
      mem[0] = 32'h0013_4581;
      stream(32'h700, 1'b0, 1, 1'b0, c);
      @(negedge clk);
      rst_n             = 1'b0;
      bus.branch_i      = 1'b1;
      bus.branch_addr_i = 32'h702;
      bus.fetch_valid_i = 1'b1;
      bus.fetch_rdata_i = 32'h0000_0013;
      bus.fetch_addr_i  = 32'h800;
      #1;
      chk("midrst_valid", {31'b0, bus.instr_valid_o}, 32'd0);
      chk("midrst_ready", {31'b0, bus.fetch_ready_o}, 32'd0);
      @(negedge clk);
      rst_n        = 1'b1;
      bus.branch_i = 1'b0;
      #1;
      chk("midrst_after_valid", {31'b0, bus.instr_valid_o}, 32'd1);
      chk("midrst_after_instr", bus.instr_o, 32'h0000_0013);
      chk("midrst_after_addr", bus.instr_addr_o, 32'h800);
      $display("instr %08h @ %08h", bus.instr_o, bus.instr_addr_o);
      @(negedge clk);
      bus.fetch_valid_i = 1'b0;

      // Random streams, including targets close to address wrap-around.
      for (int s = 0; s < 40; s++) begin
         n = $urandom_range(1, 12);
         base = {$urandom, 2'b00} & 32'hFFFF_FFFC;
         if (s % 5 == 0) base = 32'hFFFF_FFF0;
         off = 1'($urandom_range(0, 1));
         for (int i = 0; i < n; i++) mem[i] = {rand_half(), rand_half()};
         stream(base, off, n, 1'b1, c);
         chk("rand_words_used", 32'(c), 32'(n));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
